// File: rtl/conv_window_streamer_if.sv
// Pixel-in / window-out stream bundle for conv_window_streamer.
// The design sits on the slave modport and the upstream/downstream driver on master.
interface conv_window_streamer_if #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 10
);
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [9*DATA_W-1:0] out_window;
  logic [DIM_W-1:0]    out_row;
  logic [DIM_W-1:0]    out_col;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_window, out_row, out_col
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_window, out_row, out_col
  );
endinterface

// File: rtl/conv_window_streamer.sv
// Streams a raster-order frame and emits every valid-mode 3x3 window with its
// top-left coordinate, using two line buffers and a 3x3 column shift register.
module conv_window_streamer #(
  parameter int DATA_W   = 32,
  parameter int MAX_COLS = 64,
  parameter int DIM_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIM_W-1:0]       i_cfg_rows,
  input  logic [DIM_W-1:0]       i_cfg_cols,
  input  logic                   i_start,
  output logic                   o_done,
  output logic                   o_err,
  conv_window_streamer_if.slave  s_strm
);

  localparam int               COL_AW     = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [DIM_W-1:0] ONE        = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO        = DIM_W'(2);
  localparam logic [DIM_W-1:0] THREE      = DIM_W'(3);
  localparam logic [DIM_W-1:0] MAX_COLS_D = DIM_W'(MAX_COLS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [DIM_W-1:0]       r_rows;
  logic [DIM_W-1:0]       r_cols;
  logic [DIM_W-1:0]       r_row;
  logic [DIM_W-1:0]       r_col;
  logic [DIM_W-1:0]       r_out_row;
  logic [DIM_W-1:0]       r_out_col;
  logic                   r_out_valid;
  logic                   r_done;
  logic                   r_err;
  logic [8:0][DATA_W-1:0] r_win;
  logic [DATA_W-1:0]      r_linebuf0 [MAX_COLS];
  logic [DATA_W-1:0]      r_linebuf1 [MAX_COLS];

  logic              w_cfg_ok;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last_col;
  logic              w_last_pix;
  logic              w_emit;
  logic [COL_AW-1:0] w_col_idx;
  logic [DATA_W-1:0] w_lb0_rd;
  logic [DATA_W-1:0] w_lb1_rd;

  assign w_cfg_ok    = (i_cfg_rows >= THREE) && (i_cfg_cols >= THREE) &&
                       (i_cfg_cols <= MAX_COLS_D);
  assign w_start_ok  = (r_state == S_IDLE) && i_start && w_cfg_ok;
  assign w_start_bad = (r_state == S_IDLE) && i_start && !w_cfg_ok;

  // Single output register without skid: a new pixel may enter only if the
  // held window is empty or leaving this cycle.
  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || s_strm.out_ready);
  assign w_in_fire  = s_strm.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && s_strm.out_ready;

  assign w_last_col = (r_col == r_cols - ONE);
  assign w_last_pix = w_last_col && (r_row == r_rows - ONE);
  assign w_emit     = (r_row >= TWO) && (r_col >= TWO);

  assign w_col_idx = r_col[COL_AW-1:0];
  assign w_lb0_rd  = r_linebuf0[w_col_idx];
  assign w_lb1_rd  = r_linebuf1[w_col_idx];

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // always_ff sees pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // DRAIN is left one cycle after the final transfer, i.e. after the done pulse,
  // so a start coinciding with done still lands outside IDLE.
  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_RUN;
      S_RUN:   if (w_in_fire && w_last_pix) w_next_state = S_DRAIN;
      S_DRAIN: if (r_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows      <= '0;
      r_cols      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_win       <= '0;
    end else begin
      r_done <= (r_state == S_DRAIN) && w_out_fire;
      r_err  <= w_start_bad;

      if (w_start_ok) begin
        r_rows <= i_cfg_rows;
        r_cols <= i_cfg_cols;
        r_row  <= '0;
        r_col  <= '0;
      end

      if (w_out_fire) r_out_valid <= 1'b0;

      if (w_in_fire) begin
        for (int k = 0; k < 3; k++) begin
          r_win[3*k]   <= r_win[3*k+1];
          r_win[3*k+1] <= r_win[3*k+2];
        end
        r_win[2] <= w_lb1_rd;
        r_win[5] <= w_lb0_rd;
        r_win[8] <= s_strm.in_data;

        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + ONE;
        end else begin
          r_col <= r_col + ONE;
        end

        if (w_emit) begin
          r_out_valid <= 1'b1;
          r_out_row   <= r_row - TWO;
          r_out_col   <= r_col - TWO;
        end
      end
    end
  end

  // NOTE: line-buffer storage is deliberately not reset so it can map onto RAM;
  // stale contents only ever feed rows 0-1, which never produce a window.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_linebuf1[w_col_idx] <= w_lb0_rd;
      r_linebuf0[w_col_idx] <= s_strm.in_data;
    end
  end

  assign s_strm.in_ready   = w_in_ready;
  assign s_strm.out_valid  = r_out_valid;
  assign s_strm.out_window = r_win;
  assign s_strm.out_row    = r_out_row;
  assign s_strm.out_col    = r_out_col;
  assign o_done            = r_done;
  assign o_err             = r_err;

endmodule
